// File: rtl/led_display_package.sv
// Shared pixel/row types for the LED display path plus the HUB75 driver state
// encoding and the helper that picks one column's colour bits out of a row.
package led_display_package;

  localparam int unsigned PXL_COLS  = 64;
  localparam int unsigned PXL_COL_W = $clog2(PXL_COLS);

  typedef struct packed {
    logic [PXL_COLS-1:0] blue;
    logic [PXL_COLS-1:0] green;
    logic [PXL_COLS-1:0] red;
  } pxl_col_t;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StWait,
    StLatch
  } drv_state_t;

  localparam int unsigned RGB_RED   = 0;
  localparam int unsigned RGB_GREEN = 1;
  localparam int unsigned RGB_BLUE  = 2;

  // One column of a row as the 3-bit serial lane value {blue, green, red}.
  function automatic logic [2:0] pxl_bits(input pxl_col_t p, input logic [PXL_COL_W-1:0] k);
    logic [2:0] bits;
    bits            = '0;
    bits[RGB_RED]   = p.red[k];
    bits[RGB_GREEN] = p.green[k];
    bits[RGB_BLUE]  = p.blue[k];
    return bits;
  endfunction

endpackage

// File: rtl/hub75_oe_timer.sv
// Display-time counter for the HUB75 driver: holds the panel lit (oe_out low)
// for the loaded number of bclk cycles and tells the FSM when the row is done.
module hub75_oe_timer #(
  parameter int unsigned ON_W = 16
) (
  input  logic            bclk,
  input  logic            n_reset,
  input  logic            load,
  input  logic [ON_W-1:0] load_val,
  output logic            oe_out,
  output logic            done,
  output logic            active
);

  logic [ON_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge bclk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active = (cnt_q != '0);
  assign oe_out = !active;
  // Counter reaches zero on the coming edge, so the next latch can follow the
  // last lit cycle without an extra blank cycle.
  assign done   = (cnt_q[ON_W-1:1] == '0);

endmodule

// File: rtl/hub75_row_driver.sv
// HUB75 row driver: double-row shadow buffer, serial shift at bclk/2, latch and
// display timing. Define HUB75_DRV_DEADTIME_EN for blanking around the latch.
module hub75_row_driver
  import led_display_package::*;
#(
  parameter int unsigned NUM_COLS  = PXL_COLS,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned ON_W      = 16,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic              bclk,
  input  logic              n_reset,
  input  logic              row_valid,
  output logic              row_ready,
  input  pxl_col_t          row_top,
  input  pxl_col_t          row_bot,
  input  logic [ADDR_W-1:0] row_addr,
  input  logic [ON_W-1:0]   on_cycles,
  output logic              sclk,
  output logic [2:0]        rgb_top,
  output logic [2:0]        rgb_bot,
  output logic [ADDR_W-1:0] addr_out,
  output logic              le_out,
  output logic              oe_out,
  output logic              busy
);

  localparam int unsigned COL_W = $clog2(NUM_COLS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam int unsigned LAT_W = $clog2(2 * BLANK_CYC + 2);

`ifdef HUB75_DRV_DEADTIME_EN
  localparam logic [LAT_W-1:0] LE_AT   = LAT_W'(BLANK_CYC);
  localparam logic [LAT_W-1:0] LAT_END = LAT_W'(2 * BLANK_CYC);
`else
  localparam logic [LAT_W-1:0] LE_AT   = '0;
  localparam logic [LAT_W-1:0] LAT_END = '0;
`endif

  // Shadow register: the next row, filled while the current one shifts/displays.
  logic              shadow_full_q;
  pxl_col_t          sh_top_q, sh_bot_q;
  logic [ADDR_W-1:0] sh_addr_q;
  logic [ON_W-1:0]   sh_on_q;

  // Row currently being shifted / awaiting its latch.
  pxl_col_t          cur_top_q, cur_bot_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ON_W-1:0]   cur_on_q;

  drv_state_t        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              phase_q, phase_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              le_q, le_d;
  logic [ADDR_W-1:0] addr_q;
  logic              load_row, disp_load;
  logic              disp_done, disp_active;
  logic              xfer;

  assign row_ready = !shadow_full_q;
  assign xfer      = row_valid && row_ready;

  always_ff @(posedge bclk or negedge n_reset) begin
    if (!n_reset) begin
      shadow_full_q <= 1'b0;
      sh_top_q      <= '0;
      sh_bot_q      <= '0;
      sh_addr_q     <= '0;
      sh_on_q       <= '0;
    end else if (xfer) begin
      shadow_full_q <= 1'b1;
      sh_top_q      <= row_top;
      sh_bot_q      <= row_bot;
      sh_addr_q     <= row_addr;
      sh_on_q       <= on_cycles;
    end else if (load_row) begin
      shadow_full_q <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    phase_d   = phase_q;
    lat_d     = lat_q;
    load_row  = 1'b0;
    disp_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (shadow_full_q) begin
          load_row = 1'b1;
          state_d  = StShift;
          col_d    = COL_LAST;
          phase_d  = 1'b0;
        end
      end
      StShift: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q == '0) begin
            if (disp_done) begin
              state_d = StLatch;
              lat_d   = '0;
            end else begin
              state_d = StWait;
            end
          end else begin
            col_d = col_q - 1'b1;
          end
        end
      end
      StWait: begin
        if (disp_done) begin
          state_d = StLatch;
          lat_d   = '0;
        end
      end
      StLatch: begin
        if (lat_q == LAT_END) begin
          disp_load = 1'b1;
          if (shadow_full_q) begin
            load_row = 1'b1;
            state_d  = StShift;
            col_d    = COL_LAST;
            phase_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    le_d = (state_d == StLatch) && (lat_d == LE_AT);
  end

  always_ff @(posedge bclk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      col_q   <= '0;
      phase_q <= 1'b0;
      lat_q   <= '0;
      le_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      phase_q <= phase_d;
      lat_q   <= lat_d;
      le_q    <= le_d;
      if (le_d) begin
        addr_q <= cur_addr_q;
      end
    end
  end

  always_ff @(posedge bclk or negedge n_reset) begin
    if (!n_reset) begin
      cur_top_q  <= '0;
      cur_bot_q  <= '0;
      cur_addr_q <= '0;
      cur_on_q   <= '0;
    end else if (load_row) begin
      cur_top_q  <= sh_top_q;
      cur_bot_q  <= sh_bot_q;
      cur_addr_q <= sh_addr_q;
      cur_on_q   <= sh_on_q;
    end
  end

  hub75_oe_timer #(
    .ON_W(ON_W)
  ) u_oe_timer (
    .bclk    (bclk),
    .n_reset (n_reset),
    .load    (disp_load),
    .load_val(cur_on_q),
    .oe_out  (oe_out),
    .done    (disp_done),
    .active  (disp_active)
  );

  // Phase A presents data with sclk low, phase B raises sclk on the same data.
  always_comb begin
    sclk    = 1'b0;
    rgb_top = '0;
    rgb_bot = '0;
    if (state_q == StShift) begin
      sclk    = phase_q;
      rgb_top = pxl_bits(cur_top_q, col_q);
      rgb_bot = pxl_bits(cur_bot_q, col_q);
    end
  end

  assign le_out   = le_q;
  assign addr_out = addr_q;
  assign busy     = (state_q != StIdle) || disp_active;

endmodule

// File: tb/tb_hub75_row_driver.sv
// Bench for hub75_row_driver: timeline reference model fills per-cycle expectations
// and a row scoreboard; a negedge monitor checks the pins and a panel shift model.
module tb_hub75_row_driver;
  import led_display_package::*;

  localparam int N    = PXL_COLS;
  localparam int MAXC = 12000;
`ifdef HUB75_DRV_DEADTIME_EN
  localparam int B = 2;
`else
  localparam int B = 0;
`endif

  typedef struct {
    logic [3:0] addr;
    pxl_col_t   top;
    pxl_col_t   bot;
    int         le;
  } exp_t;

  logic        bclk, n_reset, row_valid, row_ready;
  pxl_col_t    row_top, row_bot;
  logic [3:0]  row_addr;
  logic [15:0] on_cycles;
  logic        sclk, le_out, oe_out, busy;
  logic [2:0]  rgb_top, rgb_bot;
  logic [3:0]  addr_out;

  hub75_row_driver dut (
    .bclk     (bclk),
    .n_reset  (n_reset),
    .row_valid(row_valid),
    .row_ready(row_ready),
    .row_top  (row_top),
    .row_bot  (row_bot),
    .row_addr (row_addr),
    .on_cycles(on_cycles),
    .sclk     (sclk),
    .rgb_top  (rgb_top),
    .rgb_bot  (rgb_bot),
    .addr_out (addr_out),
    .le_out   (le_out),
    .oe_out   (oe_out),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Per-cycle expectations, indexed by the bclk edge that starts the cycle.
  bit [2:0] exp_top [MAXC];
  bit [2:0] exp_bot [MAXC];
  bit       exp_sclk[MAXC];
  bit       exp_le  [MAXC];
  bit [3:0] exp_addr[MAXC];
  bit       exp_lit [MAXC];
  bit       exp_busy[MAXC];
  exp_t     sbq[$];

  int last_e, last_d, last_s, last_x;
  // Monitor-side panel model.
  pxl_col_t ptop, pbot;
  int       rises;
  logic     sclk_prev;
  logic [3:0] model_addr;
  exp_t     cur_e;

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;
  always @(posedge bclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic pxl_col_t rand_row();
    pxl_col_t p;
    p.red   = {$urandom, $urandom};
    p.green = {$urandom, $urandom};
    p.blue  = {$urandom, $urandom};
    return p;
  endfunction

  task automatic model_reset();
    sbq.delete();
    for (int k = cyc; k < MAXC; k++) begin
      exp_top[k] = '0; exp_bot[k] = '0; exp_sclk[k] = 1'b0; exp_le[k] = 1'b0;
      exp_addr[k] = '0; exp_lit[k] = 1'b0; exp_busy[k] = 1'b0;
    end
    last_e = 0; last_d = 0; rises = 0; sclk_prev = 1'b0;
    model_addr = '0; ptop = '0; pbot = '0;
  endtask

  // Row accepted at edge x: shifting starts once the previous row has latched,
  // latch waits for both the shift and the previous display to finish.
  task automatic model_issue(input int x, input logic [3:0] a, input pxl_col_t t,
                             input pxl_col_t b, input int on);
    exp_t e;
    int s, l, le, ee, last_busy;
    logic [5:0] j;
    s  = imax(x + 1, last_e);
    l  = imax(s + 2 * N, last_d);
    le = l + B;
    ee = l + 2 * B + 1;
    for (int k = 0; k < 2 * N; k++) begin
      j = 6'(N - 1 - k / 2);
      if (s + k < MAXC) begin
        exp_top[s + k]  = {t.blue[j], t.green[j], t.red[j]};
        exp_bot[s + k]  = {b.blue[j], b.green[j], b.red[j]};
        exp_sclk[s + k] = ((k % 2) == 1);
      end
    end
    if (le < MAXC) begin
      exp_le[le]   = 1'b1;
      exp_addr[le] = a;
    end
    for (int k = ee; k < ee + on && k < MAXC; k++) exp_lit[k] = 1'b1;
    last_busy = (on > 0) ? ee + on - 1 : ee - 1;
    for (int k = s; k <= last_busy && k < MAXC; k++) exp_busy[k] = 1'b1;
    e.addr = a; e.top = t; e.bot = b; e.le = le;
    sbq.push_back(e);
    last_s = s; last_x = x; last_e = ee; last_d = ee + on;
  endtask

  task automatic send(input logic [3:0] a, input pxl_col_t t, input pxl_col_t b, input int on);
    int g;
    g = 0;
    row_valid = 1'b1; row_addr = a; row_top = t; row_bot = b; on_cycles = 16'(on);
    while (!row_ready && g < 4000) begin
      @(negedge bclk);
      g++;
    end
    total++;
    if (!row_ready) begin
      bad++;
      $display("FAIL xfer_timeout cyc=%0d got=row_ready low want=row_ready high", cyc);
    end else begin
      model_issue(cyc + 1, a, t, b, on);
    end
    @(posedge bclk);
    #1;
    row_valid = 1'b0; row_addr = 4'($urandom); on_cycles = 16'($urandom);
    row_top = rand_row(); row_bot = rand_row();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge bclk);
      g++;
    end while ((busy || sbq.size() != 0 || cyc <= last_d) && g < 5000);
    total++;
    if (g >= 5000) begin
      bad++;
      $display("FAIL idle_timeout cyc=%0d got=busy %0b want=idle", cyc, busy);
    end
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_sclk"}, 256'(sclk), 256'(0));
    chk({tag, "_rgb_top"}, 256'(rgb_top), 256'(0));
    chk({tag, "_rgb_bot"}, 256'(rgb_bot), 256'(0));
    chk({tag, "_addr"}, 256'(addr_out), 256'(0));
    chk({tag, "_le"}, 256'(le_out), 256'(0));
    chk({tag, "_oe"}, 256'(oe_out), 256'(1));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_ready"}, 256'(row_ready), 256'(1));
  endtask

  always @(negedge bclk) begin
    if (n_reset && cyc < MAXC) begin
      if (exp_le[cyc]) model_addr = exp_addr[cyc];
      chk("sclk", 256'(sclk), 256'(exp_sclk[cyc]));
      chk("rgb_top", 256'(rgb_top), 256'(exp_top[cyc]));
      chk("rgb_bot", 256'(rgb_bot), 256'(exp_bot[cyc]));
      chk("le_out", 256'(le_out), 256'(exp_le[cyc]));
      chk("oe_out", 256'(oe_out), 256'(!exp_lit[cyc]));
      chk("busy", 256'(busy), 256'(exp_busy[cyc]));
      chk("addr_out", 256'(addr_out), 256'(model_addr));
      if (sclk && !sclk_prev) begin
        ptop.red   = {ptop.red[N-2:0], rgb_top[RGB_RED]};
        ptop.green = {ptop.green[N-2:0], rgb_top[RGB_GREEN]};
        ptop.blue  = {ptop.blue[N-2:0], rgb_top[RGB_BLUE]};
        pbot.red   = {pbot.red[N-2:0], rgb_bot[RGB_RED]};
        pbot.green = {pbot.green[N-2:0], rgb_bot[RGB_GREEN]};
        pbot.blue  = {pbot.blue[N-2:0], rgb_bot[RGB_BLUE]};
        rises++;
      end
      sclk_prev = sclk;
      if (le_out) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL le_spurious cyc=%0d got=le_out high want=no pending row", cyc);
        end else begin
          cur_e = sbq.pop_front();
          chk("le_time", 256'(cyc), 256'(cur_e.le));
          chk("panel_top", 256'(ptop), 256'(cur_e.top));
          chk("panel_bot", 256'(pbot), 256'(cur_e.bot));
          chk("le_addr", 256'(addr_out), 256'(cur_e.addr));
          chk("sclk_rises", 256'(rises), 256'(N));
        end
        rises = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    pxl_col_t t, b;
    int x1, gap;
    n_reset = 1'b0; row_valid = 1'b0; row_addr = '0; on_cycles = '0;
    row_top = '0; row_bot = '0;
    model_reset();
    repeat (3) @(negedge bclk);
    chk_reset_pins("reset");
    #2 n_reset = 1'b1;
    model_reset();

    // Single row, idle driver.
    t = '0; t.red = 64'h8000_0000_0000_0001;
    b = '0; b.blue = '1;
    send(4'd5, t, b, 10);
    wait_idle();

    // Back-to-back rows with long display: second row overlaps the first's display.
    send(4'd3, rand_row(), rand_row(), 300);
    x1 = last_x;
    send(4'd12, rand_row(), rand_row(), 300);
    chk("accept_t2", 256'(last_x), 256'(x1 + 2));
    wait_idle();

    // Zero display time: latched but never lit.
    send(4'd9, rand_row(), rand_row(), 0);
    wait_idle();

    // Reset in the middle of column 20.
    send(4'd7, rand_row(), rand_row(), 20);
    while (cyc < last_s + 2 * (N - 1 - 20)) @(negedge bclk);
    chk("pre_reset_busy", 256'(busy), 256'(1));
    #2 n_reset = 1'b0;
    #1 chk_reset_pins("midrow");
    model_reset();
    repeat (3) @(negedge bclk);
    #2 n_reset = 1'b1;
    send(4'd14, rand_row(), rand_row(), 15);
    wait_idle();

    // Random rows with random gaps and display times.
    for (int i = 0; i < 8; i++) begin
      gap = int'($urandom_range(0, 3)) == 0 ? 0 : int'($urandom_range(1, 150));
      repeat (gap) @(negedge bclk);
      send(4'($urandom), rand_row(), rand_row(), int'($urandom_range(0, 160)));
    end
    wait_idle();

    chk("end_busy", 256'(busy), 256'(0));
    chk("end_ready", 256'(row_ready), 256'(1));
    chk("end_oe", 256'(oe_out), 256'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
